// File: rtl/systolic_ctrl.sv
// Tile-job sequencer for a ROWS x COLS MAC grid: clear, K-beat feed, skew flush, column drain.
// Optional abort path (abort/aborted ports, CLEAR_ABORT state) is built when SYSTOLIC_CTRL_ABORT_EN is defined.
module systolic_ctrl #(
   parameter int unsigned COLS = 4,
   parameter int unsigned ROWS = 4,
   parameter int unsigned KW   = 8,
   localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              feed_zero,
   output logic [2*COLS-1:0] ctl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW-1:0]     out_col
`ifdef SYSTOLIC_CTRL_ABORT_EN
   ,
   input  logic              abort,
   output logic              aborted
`endif
);

   localparam int unsigned F  = ROWS + COLS - 2;
   localparam int unsigned FW = (F > 1) ? $clog2(F) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_FLUSH,
      S_DRAIN,
      S_DONE
`ifdef SYSTOLIC_CTRL_ABORT_EN
      ,
      S_ABORT
`endif
   } state_t;

   state_t        state_q;
   logic [KW-1:0] k_q;
   logic [KW-1:0] beat_q;
   logic [FW-1:0] fl_q;
   logic [CW-1:0] col_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         fl_q    <= '0;
         col_q   <= '0;
      end else begin
`ifdef SYSTOLIC_CTRL_ABORT_EN
         if (abort && state_q != S_IDLE && state_q != S_ABORT)
            state_q <= S_ABORT;
         else
`endif
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  k_q     <= k_len;
                  beat_q  <= '0;
                  fl_q    <= '0;
                  col_q   <= '0;
                  state_q <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (k_q == '0)
                  state_q <= (F == 0) ? S_DRAIN : S_FLUSH;
               else
                  state_q <= S_FEED;
            end
            S_FEED: begin
               // Compare against k-1 so k_len = 2^KW-1 never needs the counter to wrap
               if (in_valid) begin
                  if (beat_q == k_q - KW'(1))
                     state_q <= (F == 0) ? S_DRAIN : S_FLUSH;
                  else
                     beat_q <= beat_q + KW'(1);
               end
            end
            S_FLUSH: begin
               if (fl_q == FW'(F - 1))
                  state_q <= S_DRAIN;
               else
                  fl_q <= fl_q + FW'(1);
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (col_q == CW'(COLS - 1))
                     state_q <= S_DONE;
                  else
                     col_q <= col_q + CW'(1);
               end
            end
            S_DONE:  state_q <= S_IDLE;
`ifdef SYSTOLIC_CTRL_ABORT_EN
            S_ABORT: state_q <= S_IDLE;
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      in_ready  = (state_q == S_FEED);
      out_valid = (state_q == S_DRAIN);
      feed_zero = (state_q != S_FEED);
      out_col   = col_q;
      ctl       = '1;
`ifdef SYSTOLIC_CTRL_ABORT_EN
      aborted   = (state_q == S_ABORT);
`endif
      case (state_q)
         S_CLEAR: ctl = '0;
         S_FEED:  ctl = in_valid ? {COLS{2'b10}} : '1;
         S_FLUSH: ctl = {COLS{2'b10}};
         S_DRAIN: begin
            for (int unsigned c = 0; c < COLS; c++)
               ctl[2*c +: 2] = (CW'(c) == col_q) ? 2'b01 : 2'b10;
         end
`ifdef SYSTOLIC_CTRL_ABORT_EN
         S_ABORT: ctl = '0;
`endif
         default: ctl = '1;
      endcase
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (COLS=ROWS=4, KW=8); per-cycle expected vectors are hand-written.
// Abort scenario is compiled only when SYSTOLIC_CTRL_ABORT_EN is defined.
module tb_systolic_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] k_len = '0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       busy, done, in_ready, feed_zero, out_valid;
   logic [7:0] ctl;
   logic [1:0] out_col;
`ifdef SYSTOLIC_CTRL_ABORT_EN
   logic       abort = 1'b0;
   logic       aborted;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // status word order: {busy, done, in_ready, out_valid, feed_zero}
   localparam logic [4:0] IDL = 5'b00001;
   localparam logic [4:0] CLR = 5'b10001;
   localparam logic [4:0] FED = 5'b10100;
   localparam logic [4:0] FLS = 5'b10001;
   localparam logic [4:0] DRN = 5'b10011;
   localparam logic [4:0] DNE = 5'b11001;

   typedef struct packed {
      logic       iv;
      logic       ordy;
      logic [7:0] ctl;
      logic [4:0] st;
      logic [1:0] col;
   } vec_t;

   systolic_ctrl #(.COLS(4), .ROWS(4), .KW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .feed_zero (feed_zero),
      .ctl       (ctl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col)
`ifdef SYSTOLIC_CTRL_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t v(logic iv, logic ordy, logic [7:0] c, logic [4:0] st, logic [1:0] col);
      vec_t r;
      r.iv = iv; r.ordy = ordy; r.ctl = c; r.st = st; r.col = col;
      return r;
   endfunction

   task automatic test_reset();
      #2;
      n_cmp++;
      if (ctl !== 8'hFF) begin n_bad++; $display("FAIL reset ctl: got %h want ff", ctl); end
      n_cmp++;
      if ({busy, done, in_ready, out_valid, feed_zero} !== IDL) begin
         n_bad++; $display("FAIL reset status: got %b want %b", {busy, done, in_ready, out_valid, feed_zero}, IDL);
      end
      n_cmp++;
      if (out_col !== 2'd0) begin n_bad++; $display("FAIL reset out_col: got %0d want 0", out_col); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // k=3, no stalls; a stray start mid-job and a k_len change after latching must be ignored
   task automatic test_basic();
      vec_t tab[$];
      tab = {v(0, 0, 8'hFF, IDL, 0), v(0, 0, 8'h00, CLR, 0)};
      repeat (3) tab.push_back(v(1, 0, 8'hAA, FED, 0));
      repeat (6) tab.push_back(v(0, 0, 8'hAA, FLS, 0));
      tab.push_back(v(0, 1, 8'hA9, DRN, 0));
      tab.push_back(v(0, 1, 8'hA6, DRN, 1));
      tab.push_back(v(0, 1, 8'h9A, DRN, 2));
      tab.push_back(v(0, 1, 8'h6A, DRN, 3));
      tab.push_back(v(0, 0, 8'hFF, DNE, 0));
      tab.push_back(v(0, 0, 8'hFF, IDL, 0));
      for (int i = 0; i < tab.size(); i++) begin
         start = (i == 0) || (i == 8);
         k_len = (i == 0) ? 8'd3 : 8'd200;
         in_valid = tab[i].iv; out_ready = tab[i].ordy;
         #1;
         n_cmp++;
         if (ctl !== tab[i].ctl) begin n_bad++; $display("FAIL basic ctl cyc %0d: got %h want %h", i, ctl, tab[i].ctl); end
         n_cmp++;
         if ({busy, done, in_ready, out_valid, feed_zero} !== tab[i].st) begin
            n_bad++; $display("FAIL basic status cyc %0d: got %b want %b", i, {busy, done, in_ready, out_valid, feed_zero}, tab[i].st);
         end
         if (tab[i].st == DRN) begin
            n_cmp++;
            if (out_col !== tab[i].col) begin n_bad++; $display("FAIL basic out_col cyc %0d: got %0d want %0d", i, out_col, tab[i].col); end
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   // in_valid low for 2 cycles after beat 1: PEs hold, in_ready stays up, done 2 cycles later
   task automatic test_in_stall();
      vec_t tab[$];
      tab = {v(0, 0, 8'hFF, IDL, 0), v(0, 0, 8'h00, CLR, 0), v(1, 0, 8'hAA, FED, 0),
             v(0, 0, 8'hFF, FED, 0), v(0, 0, 8'hFF, FED, 0),
             v(1, 0, 8'hAA, FED, 0), v(1, 0, 8'hAA, FED, 0)};
      repeat (6) tab.push_back(v(0, 0, 8'hAA, FLS, 0));
      tab.push_back(v(0, 1, 8'hA9, DRN, 0));
      tab.push_back(v(0, 1, 8'hA6, DRN, 1));
      tab.push_back(v(0, 1, 8'h9A, DRN, 2));
      tab.push_back(v(0, 1, 8'h6A, DRN, 3));
      tab.push_back(v(0, 0, 8'hFF, DNE, 0));
      tab.push_back(v(0, 0, 8'hFF, IDL, 0));
      for (int i = 0; i < tab.size(); i++) begin
         start = (i == 0); k_len = 8'd3;
         in_valid = tab[i].iv; out_ready = tab[i].ordy;
         #1;
         n_cmp++;
         if (ctl !== tab[i].ctl) begin n_bad++; $display("FAIL in_stall ctl cyc %0d: got %h want %h", i, ctl, tab[i].ctl); end
         n_cmp++;
         if ({busy, done, in_ready, out_valid, feed_zero} !== tab[i].st) begin
            n_bad++; $display("FAIL in_stall status cyc %0d: got %b want %b", i, {busy, done, in_ready, out_valid, feed_zero}, tab[i].st);
         end
         if (tab[i].st == DRN) begin
            n_cmp++;
            if (out_col !== tab[i].col) begin n_bad++; $display("FAIL in_stall out_col cyc %0d: got %0d want %0d", i, out_col, tab[i].col); end
         end
         @(posedge clk); #1;
      end
   endtask

   // out_ready low for 3 cycles while column 2 is presented
   task automatic test_out_stall();
      vec_t tab[$];
      tab = {v(0, 0, 8'hFF, IDL, 0), v(0, 0, 8'h00, CLR, 0)};
      repeat (3) tab.push_back(v(1, 0, 8'hAA, FED, 0));
      repeat (6) tab.push_back(v(0, 0, 8'hAA, FLS, 0));
      tab.push_back(v(0, 1, 8'hA9, DRN, 0));
      tab.push_back(v(0, 1, 8'hA6, DRN, 1));
      repeat (3) tab.push_back(v(0, 0, 8'h9A, DRN, 2));
      tab.push_back(v(0, 1, 8'h9A, DRN, 2));
      tab.push_back(v(0, 1, 8'h6A, DRN, 3));
      tab.push_back(v(0, 0, 8'hFF, DNE, 0));
      tab.push_back(v(0, 0, 8'hFF, IDL, 0));
      for (int i = 0; i < tab.size(); i++) begin
         start = (i == 0); k_len = 8'd3;
         in_valid = tab[i].iv; out_ready = tab[i].ordy;
         #1;
         n_cmp++;
         if (ctl !== tab[i].ctl) begin n_bad++; $display("FAIL out_stall ctl cyc %0d: got %h want %h", i, ctl, tab[i].ctl); end
         n_cmp++;
         if ({busy, done, in_ready, out_valid, feed_zero} !== tab[i].st) begin
            n_bad++; $display("FAIL out_stall status cyc %0d: got %b want %b", i, {busy, done, in_ready, out_valid, feed_zero}, tab[i].st);
         end
         if (tab[i].st == DRN) begin
            n_cmp++;
            if (out_col !== tab[i].col) begin n_bad++; $display("FAIL out_stall out_col cyc %0d: got %0d want %0d", i, out_col, tab[i].col); end
         end
         @(posedge clk); #1;
      end
   endtask

   // k_len=0: CLEAR goes straight to FLUSH; in_valid held high yet in_ready never rises
   task automatic test_kzero();
      vec_t tab[$];
      tab = {v(1, 0, 8'hFF, IDL, 0), v(1, 0, 8'h00, CLR, 0)};
      repeat (6) tab.push_back(v(1, 0, 8'hAA, FLS, 0));
      tab.push_back(v(1, 1, 8'hA9, DRN, 0));
      tab.push_back(v(1, 1, 8'hA6, DRN, 1));
      tab.push_back(v(1, 1, 8'h9A, DRN, 2));
      tab.push_back(v(1, 1, 8'h6A, DRN, 3));
      tab.push_back(v(1, 0, 8'hFF, DNE, 0));
      tab.push_back(v(0, 0, 8'hFF, IDL, 0));
      for (int i = 0; i < tab.size(); i++) begin
         start = (i == 0);
         k_len = (i == 0) ? 8'd0 : 8'd5;
         in_valid = tab[i].iv; out_ready = tab[i].ordy;
         #1;
         n_cmp++;
         if (ctl !== tab[i].ctl) begin n_bad++; $display("FAIL kzero ctl cyc %0d: got %h want %h", i, ctl, tab[i].ctl); end
         n_cmp++;
         if ({busy, done, in_ready, out_valid, feed_zero} !== tab[i].st) begin
            n_bad++; $display("FAIL kzero status cyc %0d: got %b want %b", i, {busy, done, in_ready, out_valid, feed_zero}, tab[i].st);
         end
         if (tab[i].st == DRN) begin
            n_cmp++;
            if (out_col !== tab[i].col) begin n_bad++; $display("FAIL kzero out_col cyc %0d: got %0d want %0d", i, out_col, tab[i].col); end
         end
         @(posedge clk); #1;
      end
   endtask

   // reset during FLUSH returns to IDLE at once; a fresh job then completes with full latency
   task automatic test_reset_mid();
      int n;
      in_valid = 1'b1; out_ready = 1'b1; k_len = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== 8'hFF) begin n_bad++; $display("FAIL reset_mid ctl: got %h want ff", ctl); end
      n_cmp++;
      if ({busy, done, in_ready, out_valid, feed_zero} !== IDL) begin
         n_bad++; $display("FAIL reset_mid status: got %b want %b", {busy, done, in_ready, out_valid, feed_zero}, IDL);
      end
      repeat (3) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_mid hold busy/done: got %b want 00", {busy, done}); end
      end
      rst = 1'b1;
      #1;
      start = 1'b1; k_len = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      n_cmp++;
      if (n !== 15) begin n_bad++; $display("FAIL reset_mid job latency: got %0d want 15", n); end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_mid post-job busy/done: got %b want 00", {busy, done}); end
   endtask

`ifdef SYSTOLIC_CTRL_ABORT_EN
   // abort while column 1 is presented: one CLEAR_ABORT cycle, then IDLE without done
   task automatic test_abort();
      in_valid = 1'b1; out_ready = 1'b1; k_len = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      abort = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== 8'hA6 || out_col !== 2'd1) begin n_bad++; $display("FAIL abort pre ctl/col: got %h/%0d want a6/1", ctl, out_col); end
      @(posedge clk); #1;
      abort = 1'b0;
      #1;
      n_cmp++;
      if ({ctl, aborted, done} !== {8'h00, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL abort cycle ctl/aborted/done: got %h/%b/%b want 00/1/0", ctl, aborted, done);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, aborted} !== 3'b000) begin n_bad++; $display("FAIL abort after busy/done/aborted: got %b want 000", {busy, done, aborted}); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_in_stall();
      test_out_stall();
      test_kzero();
      test_reset_mid();
`ifdef SYSTOLIC_CTRL_ABORT_EN
      test_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
